// File: rtl/rcs_sweep_checker.sv
// ============================================================================
// Module   : rcs_sweep_checker
// Summary  : Exhaustive (a, b) operand sweep for a subtractor under test.
//            Each response is compared with a golden a-b, and mismatches are
//            counted. The first failing pair is also latched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rcs_sweep_checker #(
    parameter int WIDTH     = 8,
    parameter int SETTLE    = 1,
    parameter int CARRY_POL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   diff_in,
    input  logic               borrow_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   err_count,
    output logic               first_err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b
);

    localparam int c_CW  = 2 * WIDTH + 1;
    localparam int c_WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [c_WCW-1:0] c_WLAST = c_WCW'(SETTLE - 1);
    localparam logic             c_POL   = (CARRY_POL != 0);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_WCW-1:0] r_wcnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [c_CW-1:0]  r_err_count;
    logic             r_done;
    logic             r_fev;
    logic [WIDTH-1:0] r_fa;
    logic [WIDTH-1:0] r_fb;

    logic             w_accept;
    logic             w_check;
    logic             w_last_wait;
    logic             w_last_pair;
    logic [WIDTH-1:0] w_exp_diff;
    logic             w_exp_bw;
    logic             w_mismatch;
    logic             w_busy;

    assign w_last_wait = (r_wcnt == c_WLAST);
    assign w_last_pair = (&r_a) & (&r_b);
    assign w_exp_diff  = r_a - r_b;
    assign w_exp_bw    = (r_a < r_b) ^ c_POL;
    assign w_mismatch  = (diff_in != w_exp_diff) || (borrow_in != w_exp_bw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_WAIT;
            c_WAIT:  if (w_last_wait) w_next_state = c_CHECK;
            c_CHECK: w_next_state = w_last_pair ? c_IDLE : c_WAIT;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != c_IDLE);
        w_accept = (r_state == c_IDLE) && start;
        w_check  = (r_state == c_CHECK);
    end

    // Datapath: operand stepping, error accounting, settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_err_count <= '0;
            r_done      <= 1'b0;
            r_fev       <= 1'b0;
            r_fa        <= '0;
            r_fb        <= '0;
        end else begin
            r_done <= w_check && w_last_pair;

            if (w_accept) begin
                r_wcnt <= '0;
            end else if (r_state == c_WAIT) begin
                r_wcnt <= w_last_wait ? '0 : r_wcnt + c_WCW'(1);
            end

            if (w_accept) begin
                r_a         <= '0;
                r_b         <= '0;
                r_err_count <= '0;
                r_fev       <= 1'b0;
                r_fa        <= '0;
                r_fb        <= '0;
            end else if (w_check) begin
                if (w_mismatch) begin
                    r_err_count <= r_err_count + c_CW'(1);
                    if (!r_fev) begin
                        r_fev <= 1'b1;
                        r_fa  <= r_a;
                        r_fb  <= r_b;
                    end
                end
                // Operands freeze at all-ones once the final pair is checked.
                if (!w_last_pair) begin
                    if (&r_b) begin
                        r_b <= '0;
                        r_a <= r_a + WIDTH'(1);
                    end else begin
                        r_b <= r_b + WIDTH'(1);
                    end
                end
            end
        end
    end

    assign a_out           = r_a;
    assign b_out           = r_b;
    assign busy            = w_busy;
    assign done            = r_done;
    assign err_count       = r_err_count;
    assign first_err_valid = r_fev;
    assign first_err_a     = r_fa;
    assign first_err_b     = r_fb;

endmodule

`default_nettype wire

// File: tb/tb_rcs_sweep_checker.sv
// ============================================================================
// Module   : tb_rcs_sweep_checker
// Summary  : Directed bench with a behavioural subtractor (optionally faulty)
//            feeding three checker variants; results come from a scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rcs_sweep_checker;

    localparam int W = 4;

    typedef struct {
        int       err;
        bit       fev;
        logic [3:0] fa;
        logic [3:0] fb;
        int       len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start   [3];
    logic [W-1:0] a_o   [3];
    logic [W-1:0] b_o   [3];
    logic [W-1:0] dd    [3];
    logic       bb      [3];
    logic       busy_o  [3];
    logic       done_o  [3];
    logic [2*W:0] errc  [3];
    logic       fev_o   [3];
    logic [W-1:0] fa_o  [3];
    logic [W-1:0] fb_o  [3];

    int   cyc = 0;
    int   c0 [3] = '{0, 0, 0};
    int   fmode = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural subtractor: 0 ideal, 1 diff bit0 stuck-at-0,
    // 2 borrow inverted, 3 corrupt instance 2 outside its CHECK cycle.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dd[k] = a_o[k] - b_o[k];
            bb[k] = (a_o[k] < b_o[k]);
            if (fmode == 1) dd[k][0] = 1'b0;
            if (fmode == 2) bb[k] = ~bb[k];
            if (fmode == 3 && k == 2 && ((cyc - c0[2]) % 4) != 3) begin
                dd[k] = ~dd[k];
                bb[k] = ~bb[k];
            end
        end
    end

    rcs_sweep_checker #(.WIDTH(W), .SETTLE(1), .CARRY_POL(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
        .diff_in(dd[0]), .borrow_in(bb[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err_count(errc[0]), .first_err_valid(fev_o[0]),
        .first_err_a(fa_o[0]), .first_err_b(fb_o[0]));

    rcs_sweep_checker #(.WIDTH(W), .SETTLE(1), .CARRY_POL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
        .diff_in(dd[1]), .borrow_in(bb[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err_count(errc[1]), .first_err_valid(fev_o[1]),
        .first_err_a(fa_o[1]), .first_err_b(fb_o[1]));

    rcs_sweep_checker #(.WIDTH(W), .SETTLE(3), .CARRY_POL(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .a_out(a_o[2]), .b_out(b_o[2]),
        .diff_in(dd[2]), .borrow_in(bb[2]), .busy(busy_o[2]), .done(done_o[2]),
        .err_count(errc[2]), .first_err_valid(fev_o[2]),
        .first_err_a(fa_o[2]), .first_err_b(fb_o[2]));

    function automatic int settle_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int k, input int err, input bit fev,
                            input logic [3:0] fa, input logic [3:0] fb);
        exp_t e;
        e.err = err; e.fev = fev; e.fa = fa; e.fb = fb;
        e.len = 256 * (settle_of(k) + 1);
        sb.push_back(e);
    endtask

    // Raise start across one rising edge (E0); c0 marks the cycle after E0.
    task automatic start_sweep(input int k, input bit hold);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        c0[k] = cyc;
        if (!hold) start[k] = 1'b0;
    endtask

    // Returns at the negedge inside the done cycle, with start dropped.
    task automatic wait_done(input int k, input bit chk_ops);
        int  n, len, s, j, idx;
        bit  seen;
        exp_t e;
        s    = settle_of(k);
        len  = (sb.size() > 0) ? sb[0].len : 256 * (s + 1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n <= len + 20) begin
            @(negedge clk);
            n++;
            if (done_o[k]) begin
                seen = 1'b1;
            end else if (chk_ops) begin
                j = cyc - c0[k];
                if (j >= 0 && j < len) begin
                    idx = j / (s + 1);
                    chk("a_out order", 32'(a_o[k]), 32'(idx / 16));
                    chk("b_out order", 32'(b_o[k]), 32'(idx % 16));
                end
            end
        end
        start[k] = 1'b0;
        chk("done seen", 32'(seen), 32'd1);
        chk("scoreboard entry", 32'(sb.size() > 0), 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("done time", 32'(cyc - c0[k]), 32'(e.len));
            chk("err_count", 32'(errc[k]), 32'(e.err));
            chk("first_err_valid", 32'(fev_o[k]), 32'(e.fev));
            chk("first_err_a", 32'(fa_o[k]), 32'(e.fa));
            chk("first_err_b", 32'(fb_o[k]), 32'(e.fb));
            chk("a_out final", 32'(a_o[k]), 32'hF);
            chk("b_out final", 32'(b_o[k]), 32'hF);
            chk("busy at done", 32'(busy_o[k]), 32'd0);
        end
    endtask

    task automatic check_after(input int k);
        @(negedge clk);
        chk("done one-shot", 32'(done_o[k]), 32'd0);
        chk("idle after done", 32'(busy_o[k]), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset a_out", 32'(a_o[0]), 32'd0);
        chk("reset b_out", 32'(b_o[0]), 32'd0);
        chk("reset busy", 32'(busy_o[0]), 32'd0);
        chk("reset done", 32'(done_o[0]), 32'd0);
        chk("reset err_count", 32'(errc[0]), 32'd0);
        chk("reset first_err_valid", 32'(fev_o[0]), 32'd0);

        // Ideal subtractor, operand order tracked every cycle.
        fmode = 0;
        push_exp(0, 0, 1'b0, 4'h0, 4'h0);
        start_sweep(0, 1'b0);
        chk("busy after start", 32'(busy_o[0]), 32'd1);
        wait_done(0, 1'b1);
        check_after(0);

        // diff bit0 stuck-at-0: odd differences fail, first at (0,1).
        fmode = 1;
        push_exp(0, 128, 1'b1, 4'h0, 4'h1);
        start_sweep(0, 1'b0);
        wait_done(0, 1'b0);
        check_after(0);

        // Inverted borrow: every pair fails under borrow convention,
        // none under carry convention.
        fmode = 2;
        push_exp(0, 256, 1'b1, 4'h0, 4'h0);
        start_sweep(0, 1'b0);
        wait_done(0, 1'b0);
        check_after(0);
        push_exp(1, 0, 1'b0, 4'h0, 4'h0);
        start_sweep(1, 1'b0);
        wait_done(1, 1'b0);
        check_after(1);

        // SETTLE=3 with responses corrupted only while waiting.
        fmode = 3;
        push_exp(2, 0, 1'b0, 4'h0, 4'h0);
        start_sweep(2, 1'b0);
        wait_done(2, 1'b1);
        check_after(2);

        // start held high for the whole sweep.
        fmode = 0;
        push_exp(0, 0, 1'b0, 4'h0, 4'h0);
        start_sweep(0, 1'b1);
        wait_done(0, 1'b0);
        check_after(0);

        // Asynchronous reset mid-sweep, with errors already accumulated.
        fmode = 1;
        start_sweep(0, 1'b0);
        repeat (99) @(negedge clk);
        chk("pre-reset errors seen", 32'(errc[0] != 0), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst a_out", 32'(a_o[0]), 32'd0);
        chk("async rst b_out", 32'(b_o[0]), 32'd0);
        chk("async rst busy", 32'(busy_o[0]), 32'd0);
        chk("async rst err_count", 32'(errc[0]), 32'd0);
        chk("async rst first_err_valid", 32'(fev_o[0]), 32'd0);
        chk("async rst first_err_b", 32'(fb_o[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fmode = 0;
        push_exp(0, 0, 1'b0, 4'h0, 4'h0);
        start_sweep(0, 1'b0);
        wait_done(0, 1'b1);
        check_after(0);

        // Back-to-back: start raised during the done cycle.
        fmode = 1;
        push_exp(0, 128, 1'b1, 4'h0, 4'h1);
        start_sweep(0, 1'b0);
        wait_done(0, 1'b0);
        start[0] = 1'b1;
        push_exp(0, 128, 1'b1, 4'h0, 4'h1);
        @(negedge clk);
        c0[0] = cyc;
        start[0] = 1'b0;
        chk("b2b busy", 32'(busy_o[0]), 32'd1);
        chk("b2b done cleared", 32'(done_o[0]), 32'd0);
        chk("b2b a_out", 32'(a_o[0]), 32'd0);
        chk("b2b b_out", 32'(b_o[0]), 32'd0);
        chk("b2b err_count", 32'(errc[0]), 32'd0);
        chk("b2b first_err_valid", 32'(fev_o[0]), 32'd0);
        wait_done(0, 1'b0);
        check_after(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
